// File: rtl/sound_stream_ctrl_pkg.sv
// Shared types and constants for the sound sample playback controller.
package sound_pkg;

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2
  } playState_t;

  localparam logic [7:0] SILENCE_DEFAULT = 8'h80;
  localparam int         COUNT_WIDTH     = 10;
  localparam logic [COUNT_WIDTH-1:0] BUF_CAPACITY = 10'd1023;
  localparam logic [COUNT_WIDTH-1:0] BUF_EMPTY    = 10'd0;

endpackage

// File: rtl/sound_stream_ctrl_rate_divider.sv
// Sample-rate divider: counts 0..max(divisor,1) and ticks on the last count.
// The limit is re-sampled only at a wrap (or while disabled), so a divisor change never cuts a period short.
module rate_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] count_r;
  logic [DIV_WIDTH-1:0] limit_r;
  logic [DIV_WIDTH-1:0] clamped_s;

  // Zero is clamped to one so the sample period never drops below two cycles
  always_comb begin
    if (divisor == DIV_ZERO) begin
      clamped_s = DIV_ONE;
    end else begin
      clamped_s = divisor;
    end
  end

  assign tick = enable && (count_r == limit_r);

  // Period counter and latched limit
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r <= DIV_ZERO;
      limit_r <= DIV_ONE;
    end else if (!enable) begin
      count_r <= DIV_ZERO;
      limit_r <= clamped_s;
    end else if (tick) begin
      count_r <= DIV_ZERO;
      limit_r <= clamped_s;
    end else begin
      count_r <= count_r + DIV_ONE;
      limit_r <= limit_r;
    end
  end

endmodule

// File: rtl/sound_stream_ctrl.sv
// Playback controller between host writes, the sample FIFO and the DAC stage.
// Gates host writes, paces reads, substitutes silence on underrun, and keeps status/IRQ.
module sound_stream_ctrl
  import sound_pkg::*;
#(
  parameter int         DIV_WIDTH = 16,
  parameter logic [7:0] SILENCE   = SILENCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 drain,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [9:0]           lowWater,
  input  logic                 irqEn,
  input  logic                 statusClear,
  input  logic                 hostWrite,
  input  logic [7:0]           hostData,
  output logic                 hostReady,
  output logic                 bufWriteEn,
  output logic [7:0]           bufDataIn,
  output logic                 bufReadReq,
  input  logic [7:0]           bufDataOut,
  input  logic [9:0]           bufWordCount,
  output logic [7:0]           sampleOut,
  output logic                 sampleStrobe,
  output logic [1:0]           state,
  output logic                 irq,
  output logic                 overrun,
  output logic                 underrun
);

  playState_t state_r;
  playState_t state_next_s;

  logic       tick_s;
  logic       full_s;
  logic       empty_s;
  logic       fetch_s;
  logic       starve_s;
  logic       issue_s;
  logic       ovr_set_s;

  logic       read_req_r;
  logic       s1_valid_r;
  logic       s1_silent_r;
  logic       s2_valid_r;
  logic       s2_silent_r;
  logic       strobe_r;
  logic [7:0] sample_r;
  logic       irq_r;
  logic       overrun_r;
  logic       underrun_r;

  rate_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate_divider (
    .clk    (clk),
    .resetN (resetN),
    .enable (state_r != STOPPED),
    .divisor(divisor),
    .tick   (tick_s)
  );

  assign full_s     = (bufWordCount == BUF_CAPACITY);
  assign empty_s    = (bufWordCount == BUF_EMPTY);
  assign hostReady  = !full_s;
  assign bufWriteEn = hostWrite && !full_s;
  assign bufDataIn  = hostData;
  assign ovr_set_s  = hostWrite && full_s;

  // A tick that coincides with stop starts nothing new
  always_comb begin
    fetch_s  = 1'b0;
    starve_s = 1'b0;
    if (tick_s && !stop) begin
      fetch_s  = !empty_s;
      starve_s = empty_s && (state_r == RUNNING);
    end else begin
      fetch_s  = 1'b0;
      starve_s = 1'b0;
    end
    issue_s = fetch_s || starve_s;
  end

  // Next-state logic: stop overrides everything, drain and start only act in their own state
  always_comb begin
    state_next_s = state_r;
    if (stop) begin
      state_next_s = STOPPED;
    end else begin
      case (state_r)
        STOPPED:  if (start) state_next_s = RUNNING;  else state_next_s = STOPPED;
        RUNNING:  if (drain) state_next_s = DRAINING; else state_next_s = RUNNING;
        DRAINING: if (tick_s && empty_s) state_next_s = STOPPED; else state_next_s = DRAINING;
        default:  state_next_s = STOPPED;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= STOPPED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read pipeline: tick -> read request -> FIFO data valid -> sample load -> strobe
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      read_req_r  <= 1'b0;
      s1_valid_r  <= 1'b0;
      s1_silent_r <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_silent_r <= 1'b0;
      strobe_r    <= 1'b0;
      sample_r    <= SILENCE;
    end else begin
      read_req_r <= fetch_s;
      if (stop) begin
        // An issued read still completes in the FIFO; only its delivery is cancelled
        s1_valid_r  <= 1'b0;
        s1_silent_r <= 1'b0;
        s2_valid_r  <= 1'b0;
        s2_silent_r <= 1'b0;
        strobe_r    <= 1'b0;
        sample_r    <= SILENCE;
      end else begin
        s1_valid_r  <= issue_s;
        s1_silent_r <= starve_s;
        s2_valid_r  <= s1_valid_r;
        s2_silent_r <= s1_silent_r;
        strobe_r    <= s2_valid_r;
        if (s2_valid_r) begin
          sample_r <= s2_silent_r ? SILENCE : bufDataOut;
        end else if (state_r == STOPPED) begin
          sample_r <= SILENCE;
        end else begin
          sample_r <= sample_r;
        end
      end
    end
  end

  // Sticky status flags; a same-cycle set wins over statusClear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (statusClear) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (starve_s) begin
        underrun_r <= 1'b1;
      end else if (statusClear) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

  // Low-water interrupt; a zero threshold can never be undercut
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irqEn && (state_r != STOPPED) && (bufWordCount < lowWater);
    end
  end

  assign bufReadReq   = read_req_r;
  assign sampleOut    = sample_r;
  assign sampleStrobe = strobe_r;
  assign state        = state_r;
  assign irq          = irq_r;
  assign overrun      = overrun_r;
  assign underrun     = underrun_r;

endmodule

// File: doc/sound_stream_ctrl.md
# sound_stream_ctrl

Playback controller for the 1024-entry sound sample FIFO (8-bit samples, 10-bit `wordCount`, no internal full/empty protection). Sits between the host register interface and the FIFO: it gates host writes so the FIFO never overflows and paces FIFO reads at a programmable sample rate. It delivers each sample to the DAC/PWM stage with a strobe and substitutes silence on underrun. It also runs the start/stop/drain state machine, keeps sticky overrun/underrun status and raises a low-water interrupt.

## Interface
- `DIV_WIDTH`, 16, sample-rate divisor width
- `SILENCE`, 8'h80, sample emitted when stopped or on underrun (unsigned midpoint)
- `clk` in 1: single clock, all logic rising-edge
- `resetN` in 1: asynchronous, active-low reset
- `start`, `stop`, `drain` in 1 each: one-cycle command pulses
- `divisor` in DIV_WIDTH: sample period = max(divisor,1)+1 cycles
- `lowWater` in 10: IRQ threshold
- `irqEn` in 1: IRQ enable
- `statusClear` in 1: pulse, clears sticky flags
- `hostWrite` in 1, `hostData` in 8: host sample write
- `hostReady` out 1: FIFO not full
- `bufWriteEn` out 1, `bufDataIn` out 8: to FIFO write port
- `bufReadReq` out 1: to FIFO read request
- `bufDataOut` in 8: FIFO registered output
- `bufWordCount` in 10: FIFO occupancy
- `sampleOut` out 8, `sampleStrobe` out 1: to DAC stage
- `state` out 2: current playState_t
- `irq` out 1, `overrun` out 1, `underrun` out 1

## Operation
- Capacity is 1023: `full` = `bufWordCount`==1023. `hostReady` = !full (combinational). `bufWriteEn` = `hostWrite` && !full. `bufDataIn` = `hostData`. Write while full is dropped and sets `overrun`. Writes are accepted in every state.
- States:
  - STOPPED: divider held at 0, no reads, `sampleOut`=SILENCE.
  - RUNNING: divider runs. A tick with count 0 is an underrun.
  - DRAINING: divider runs. A tick with count 0 moves to STOPPED and does not set `underrun`.
- Command priority is stop > drain > start.
  - `stop`: any state -> STOPPED.
  - `start`: STOPPED -> RUNNING. Ignored in other states.
  - `drain`: RUNNING -> DRAINING. Ignored in other states.
- Divider counts 0..max(divisor,1) and ticks in the cycle count equals the limit, then wraps to 0. A `divisor` change takes effect at the next wrap.
- On a tick with `bufWordCount`!=0: read path issues `bufReadReq` and `sampleOut` loads from `bufDataOut`.
- On a tick with count 0 in RUNNING: no read, `sampleOut` loads SILENCE, `sampleStrobe` still pulses, `underrun` set.
- `stop` while a read is in flight: the read completes in the FIFO, the strobe is suppressed, and `sampleOut` is forced to SILENCE.
- `irq` (registered) = `irqEn` && state!=STOPPED && `bufWordCount` < `lowWater`. `lowWater`=0 never fires.
- Sticky flags: set has priority over a same-cycle `statusClear`.
- Reset values: `state` STOPPED, `sampleOut` SILENCE; `sampleStrobe`, `bufReadReq`, `irq`, `overrun`, `underrun` and the divider all 0. `resetN` asserted mid-operation clears everything immediately. FIFO contents are the FIFO's own concern.

## Timing
- Tick in cycle T; `bufReadReq` (registered) high in T+1; FIFO count and `bufDataOut` update at the end of T+1.
- `sampleOut` loads at the end of T+2; `sampleStrobe` is high for one cycle in T+3 with the new value.
- Minimum period of 2 cycles guarantees the next availability check sees the decremented count.
- `bufWriteEn` is same-cycle with `hostWrite`. A simultaneous FIFO read and write leaves the count unchanged, and the controller needs no special case.
- `irq` lags `bufWordCount` by 1 cycle. State transitions take effect at the next edge after the command.

## Structure
- `sound_pkg`:
  - `playState_t` enum {STOPPED=0, RUNNING=1, DRAINING=2}
  - `SILENCE_DEFAULT`
  - `BUF_CAPACITY`=1023
- Sub-module `rate_divider`: counter, effective-limit clamp and tick output; enable driven by state!=STOPPED.
- Everything else lives in `sound_stream_ctrl`: FSM, read pipeline, write gate, flags, IRQ.

## Test plan
- Reset mid-RUNNING -> all outputs at reset values immediately, `sampleOut`=8'h80, `state`=0.
- Preload 0x10,0x11,0x12,0x13, divisor=3, start -> four strobes 4 cycles apart carrying 0x10..0x13, first 3 cycles after the first tick. Next strobe carries 0x80 with `underrun`=1; `statusClear` -> 0.
- 1023 writes -> `hostReady`=0. The 1024th write produces no `bufWriteEn`, `overrun`=1, count stays 1023. The first read then restores `hostReady`=1.
- Preload 2 samples, start, drain -> two strobes, `state` returns to STOPPED on the next tick, `underrun`=0. A later `start` resumes.
- divisor=0, preload 3 -> strobes every 2 cycles, no duplicated or skipped samples.
- lowWater=4, irqEn=1, count 5 draining -> `irq`=1 one cycle after count reaches 3. A host write raising count to 4 -> `irq`=0. `stop` -> `irq`=0.
